branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters. It sits in the CPU fetch stage alongside the PC register: it predicts next-PC for the current fetch address and is trained by resolved branches from the execute stage. Enabled at top level by SW[0] through the en input. It keeps a saturating mispredict counter for on-board performance readout.

Parameters:
ADDR_W, 16, PC / instruction-address width (word addressed).
IDX_W, 4, index bits; entry count = 2**IDX_W.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  BTB enable (SW[0]); 0 = predict not-taken, no training.
flush  input  1  synchronous invalidate of all entries.
if_pc  input  ADDR_W  fetch-stage PC to look up.
pred_hit  output  1  valid entry with matching tag for if_pc.
pred_taken  output  1  predict taken.
pred_target  output  ADDR_W  predicted next PC.
ex_valid  input  1  execute stage resolved a branch this cycle.
ex_pc  input  ADDR_W  PC of the resolved branch.
ex_taken  input  1  actual direction.
ex_target  input  ADDR_W  actual taken target.
ex_pred_taken  input  1  prediction that was made for this branch at fetch.
ex_pred_target  input  ADDR_W  target that was predicted at fetch.
mispredict_cnt  output  16  saturating mispredict count.

Behaviour:
- Entry fields: valid (1), tag (ADDR_W-IDX_W), target (ADDR_W), ctr (2).
- index = pc[IDX_W-1:0]; tag = pc[ADDR_W-1:IDX_W].
- Lookup is combinational, zero latency: pred_hit = en & valid[idx] & tag match; pred_taken = pred_hit & ctr[1]; pred_target = pred_taken ? target[idx] : if_pc+1 (mod 2**ADDR_W, wraps 0xFFFF->0x0000).
- en=0: pred_hit=0, pred_taken=0, pred_target=if_pc+1; no training, no count; contents retained.
- Training on rising edge when ex_valid & en & ~flush:
  - Hit at ex_pc: ctr += 1 if ex_taken (saturate 11), ctr -= 1 if not taken (saturate 00); if ex_taken, target <= ex_target.
  - Miss, ex_taken=1: allocate/replace: valid=1, tag, target=ex_target, ctr=10.
  - Miss, ex_taken=0: no change.
- Mispredict when ex_valid & en: (ex_pred_taken != ex_taken) OR (ex_taken & ex_pred_taken & ex_pred_target != ex_target). mispredict_cnt += 1, saturating at 0xFFFF. Counted even when flush is high.
- flush=1 (synchronous): all valid <= 0; overrides same-cycle training; ctr/target/tag untouched; mispredict_cnt not cleared.
- Same-cycle lookup and training of the same index: lookup returns pre-edge contents (no bypass).
- Reset (async, any time, including mid-training): valid all 0, ctr all 01, tag/target 0, mispredict_cnt 0. Outputs after reset: pred_hit=0, pred_taken=0, pred_target=if_pc+1.

Test Plan:
- Reset, en=1, if_pc=0x0010 -> pred_hit=0, pred_taken=0, pred_target=0x0011, mispredict_cnt=0.
- Train ex_pc=0x0023 taken to 0x0100 (ex_pred_taken=0); next cycle if_pc=0x0023 -> hit=1, taken=1, target=0x0100, mispredict_cnt=1.
- Same branch not-taken twice -> ctr 10->01->00; if_pc=0x0023 -> hit=1, taken=0, target=0x0024. Three taken trainings -> ctr saturates 11; one not-taken -> still predicts taken.
- Alias: train 0x0033 taken to 0x0200 (same index 3) -> if_pc=0x0023 hit=0, target=0x0024; if_pc=0x0033 target=0x0200.
- en=0 with training pulses -> no entry changes and no count; re-enable -> prior predictions intact. flush with simultaneous training -> all misses next cycle.
- Force 0x10000 mispredicts -> mispredict_cnt holds 0xFFFF; assert rst_n low mid-run -> counter and valid bits clear immediately; if_pc=0xFFFF -> pred_target=0x0000.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters and a saturating mispredict counter.
// Zero-latency combinational lookup, one-cycle training update; no backpressure (accepts every resolve).
module branch_target_buffer #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic [15:0]       mispredict_cnt
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [N-1:0]        valid_q;
  logic [TAG_W-1:0]    tag_q [N];
  logic [ADDR_W-1:0]   tgt_q [N];
  logic [1:0]          ctr_q [N];

  logic [IDX_W-1:0]    if_idx, ex_idx;
  logic [TAG_W-1:0]    if_tag, ex_tag;
  logic                ex_hit, train, mispredict;

  assign if_idx = if_pc[IDX_W-1:0];
  assign if_tag = if_pc[ADDR_W-1:IDX_W];
  assign ex_idx = ex_pc[IDX_W-1:0];
  assign ex_tag = ex_pc[ADDR_W-1:IDX_W];

  // Lookup sees pre-edge contents; no bypass from same-cycle training.
  assign pred_hit    = en & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
  assign pred_taken  = pred_hit & ctr_q[if_idx][1];
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + ADDR_W'(1);

  assign ex_hit     = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
  assign train      = ex_valid & en & ~flush;
  assign mispredict = ex_valid & en &
                      ((ex_pred_taken != ex_taken) |
                       (ex_taken & ex_pred_taken & (ex_pred_target != ex_target)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= '0;
      mispredict_cnt <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else begin
      // Counting is independent of flush so perf readout stays accurate.
      if (mispredict && (mispredict_cnt != 16'hFFFF))
        mispredict_cnt <= mispredict_cnt + 16'd1;

      if (flush) begin
        valid_q <= '0;
      end else if (train) begin
        if (ex_hit) begin
          if (ex_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
            tgt_q[ex_idx] <= ex_target;
          end else if (ctr_q[ex_idx] != 2'b00) begin
            ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          valid_q[ex_idx] <= 1'b1;
          tag_q[ex_idx]   <= ex_tag;
          tgt_q[ex_idx]   <= ex_target;
          ctr_q[ex_idx]   <= 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed + random bench for branch_target_buffer against an integer-array reference model.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst_n, en, flush, ex_valid, ex_taken, ex_pred_taken;
  logic [15:0] if_pc, ex_pc, ex_target, ex_pred_target;
  logic        pred_hit, pred_taken;
  logic [15:0] pred_target, mispredict_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: plain integer tables indexed by pc mod 16.
  bit mvalid [16];
  int mtag [16];
  int mtgt [16];
  int mctr [16];
  int mcnt;

  branch_target_buffer #(.ADDR_W(16), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  function automatic void mreset();
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0; mtag[i] = 0; mtgt[i] = 0; mctr[i] = 1;
    end
    mcnt = 0;
  endfunction

  // Applies one rising edge worth of spec rules to the model using current inputs.
  function automatic void mtrain();
    int i, t;
    bit mis;
    i = int'(ex_pc) % 16;
    t = int'(ex_pc) / 16;
    if (en && ex_valid) begin
      mis = (ex_pred_taken != ex_taken) ||
            (ex_taken && ex_pred_taken && (ex_pred_target != ex_target));
      if (mis && mcnt < 65535) mcnt++;
    end
    if (flush) begin
      for (int k = 0; k < 16; k++) mvalid[k] = 1'b0;
    end else if (en && ex_valid) begin
      if (mvalid[i] && mtag[i] == t) begin
        if (ex_taken) begin
          mctr[i] = (mctr[i] < 3) ? mctr[i] + 1 : 3;
          mtgt[i] = int'(ex_target);
        end else begin
          mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
        end
      end else if (ex_taken) begin
        mvalid[i] = 1'b1; mtag[i] = t; mtgt[i] = int'(ex_target); mctr[i] = 2;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_model();
    int  i;
    bit  h, tk;
    int  tg;
    i  = int'(if_pc) % 16;
    h  = en && mvalid[i] && (mtag[i] == int'(if_pc) / 16);
    tk = h && (mctr[i] >= 2);
    tg = tk ? mtgt[i] : (int'(if_pc) + 1) % 65536;
    chk("model_hit", {31'd0, pred_hit}, {31'd0, h});
    chk("model_taken", {31'd0, pred_taken}, {31'd0, tk});
    chk("model_target", {16'd0, pred_target}, tg);
    chk("model_cnt", {16'd0, mispredict_cnt}, mcnt);
  endtask

  // Called just after a rising edge with inputs already set.
  task automatic cyc();
    #1 check_model();
    @(posedge clk);
    mtrain();
    #1;
  endtask

  task automatic train(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                       input logic ptk, input logic [15:0] ptgt);
    ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
    cyc();
    ex_valid = 1'b0;
  endtask

  task automatic look(input string name, input logic [15:0] pc, input logic h,
                      input logic tk, input logic [15:0] tgt);
    if_pc = pc; ex_valid = 1'b0;
    #1;
    chk({name, "_hit"}, {31'd0, pred_hit}, {31'd0, h});
    chk({name, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
    chk({name, "_target"}, {16'd0, pred_target}, {16'd0, tgt});
    @(posedge clk);
    mtrain();
    #1;
  endtask

  initial begin
    int saved_cnt;
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; if_pc = 16'h0010;
    ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
    mreset();
    #1;
    chk("rst_hit", {31'd0, pred_hit}, 32'd0);
    chk("rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_target", {16'd0, pred_target}, 32'h0011);
    chk("rst_cnt", {16'd0, mispredict_cnt}, 32'd0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Allocate on taken miss.
    train(16'h0023, 1'b1, 16'h0100, 1'b0, 16'h0000);
    look("alloc", 16'h0023, 1'b1, 1'b1, 16'h0100);
    chk("alloc_cnt", {16'd0, mispredict_cnt}, 32'd1);

    // Decrement to strongly not-taken, then saturate high.
    train(16'h0023, 1'b0, 16'h0000, 1'b1, 16'h0100);
    train(16'h0023, 1'b0, 16'h0000, 1'b1, 16'h0100);
    look("ctr00", 16'h0023, 1'b1, 1'b0, 16'h0024);
    repeat (3) train(16'h0023, 1'b1, 16'h0100, 1'b0, 16'h0000);
    train(16'h0023, 1'b0, 16'h0000, 1'b1, 16'h0100);
    look("ctrsat", 16'h0023, 1'b1, 1'b1, 16'h0100);

    // Alias replaces the entry at index 3.
    train(16'h0033, 1'b1, 16'h0200, 1'b0, 16'h0000);
    look("alias_old", 16'h0023, 1'b0, 1'b0, 16'h0024);
    look("alias_new", 16'h0033, 1'b1, 1'b1, 16'h0200);

    // Disabled: no training, no counting, contents kept.
    saved_cnt = mcnt;
    en = 1'b0;
    train(16'h0033, 1'b0, 16'h0000, 1'b1, 16'h0200);
    train(16'h0044, 1'b1, 16'h0300, 1'b0, 16'h0000);
    look("dis", 16'h0033, 1'b0, 1'b0, 16'h0034);
    chk("dis_cnt", {16'd0, mispredict_cnt}, saved_cnt);
    en = 1'b1;
    look("reen", 16'h0033, 1'b1, 1'b1, 16'h0200);
    look("reen_noalloc", 16'h0044, 1'b0, 1'b0, 16'h0045);

    // Flush beats same-cycle training.
    flush = 1'b1;
    train(16'h0055, 1'b1, 16'h0400, 1'b0, 16'h0000);
    flush = 1'b0;
    look("flush_a", 16'h0033, 1'b0, 1'b0, 16'h0034);
    look("flush_b", 16'h0055, 1'b0, 1'b0, 16'h0056);

    // Random traffic over a small PC space so hits and aliases are frequent.
    for (int n = 0; n < 400; n++) begin
      en       = ($urandom_range(0, 7) != 0);
      flush    = en && ($urandom_range(0, 31) == 0);
      if_pc    = 16'({$urandom_range(0, 3), 4'(0)}) | 16'($urandom_range(0, 3));
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_pc    = 16'({$urandom_range(0, 3), 4'(0)}) | 16'($urandom_range(0, 3));
      ex_taken = 1'($urandom);
      ex_target = 16'($urandom_range(0, 3) * 16'h0100);
      ex_pred_taken = 1'($urandom);
      ex_pred_target = ($urandom_range(0, 1) == 0) ? ex_target : 16'($urandom);
      cyc();
    end
    en = 1'b1; flush = 1'b0; ex_valid = 1'b0;

    // Counter saturation.
    ex_valid = 1'b1; ex_pc = 16'h0077; ex_taken = 1'b1; ex_target = 16'h0500;
    ex_pred_taken = 1'b0; ex_pred_target = 16'h0000;
    for (int n = 0; n < 65536; n++) begin
      @(posedge clk);
      mtrain();
    end
    #1;
    chk("sat_cnt", {16'd0, mispredict_cnt}, 32'h0000FFFF);
    cyc();
    chk("sat_hold", {16'd0, mispredict_cnt}, 32'h0000FFFF);

    // Asynchronous reset mid-training clears state immediately.
    if_pc = 16'h0077;
    #2 rst_n = 1'b0;
    #1;
    mreset();
    chk("arst_cnt", {16'd0, mispredict_cnt}, 32'd0);
    chk("arst_hit", {31'd0, pred_hit}, 32'd0);
    chk("arst_target", {16'd0, pred_target}, 32'h0078);
    ex_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    look("wrap", 16'hFFFF, 1'b0, 1'b0, 16'h0000);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
